div_job_ctrl: RTL
=================

DIV_JOB_CTRL -- requirements
Module: div_job_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles in RUN before a watchdog abort.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have req_valid  input  1, req_ready  output  1, req_dividend  input  WIDTH, req_divisor  input  WIDTH, req_signed  input  1: job request channel.
REQ-006 SHALL have rsp_valid  output  1, rsp_ready  input  1, rsp_quotient  output  WIDTH, rsp_remainder  output  WIDTH, rsp_div0  output  1, rsp_err  output  1: result channel.
REQ-007 SHALL have div_reset  output  1, div_run  output  1, div_dividend  output  WIDTH, div_divisor  output  WIDTH: drive the downstream CompDivider reset/run/Dividend/Divisor.
REQ-008 SHALL have div_ready  input  1, div_quotient  input  WIDTH, div_remainder  input  WIDTH: sampled from CompDivider ready/Quotient/Remainder.

Function
REQ-009 SHALL implement FSM states IDLE, CLR, SETTLE, RUN, DONE.
REQ-010 SHALL assert req_ready only in IDLE; a transfer occurs when req_valid and req_ready are both high on a rising edge.
REQ-011 SHALL on transfer latch the operands into registers driving div_dividend/div_divisor, held stable until the job leaves RUN.
REQ-012 SHALL on transfer with divisor 0 go IDLE->DONE, bypassing the divider: quotient all-ones, remainder = dividend, rsp_div0=1.
REQ-013 SHALL otherwise go IDLE->CLR; CLR drives div_reset=1 for exactly one cycle; CLR->SETTLE.
REQ-014 SHALL in SETTLE drive div_reset=0, div_run=0 for exactly one cycle; SETTLE->RUN.
REQ-015 SHALL in RUN hold div_run=1 and detect a 0->1 transition of div_ready using a registered copy of div_ready cleared on entry to CLR.
REQ-016 SHALL on that rising edge capture div_quotient/div_remainder, drop div_run on the next cycle, and go RUN->DONE.
REQ-017 SHALL count RUN cycles; on reaching TIMEOUT_CYCLES without a ready edge go RUN->DONE with rsp_err=1, quotient=0, remainder=0.
REQ-018 SHALL assert rsp_valid only in DONE, with result fields stable; DONE->IDLE when rsp_ready is high; rsp_valid low in IDLE.
REQ-019 SHALL provide minimum latency of 1 cycle (divide-by-zero) and 3 + divider latency + 1 cycles (normal) from request transfer to rsp_valid.

Reset
REQ-020 SHALL on reset return to IDLE on the next edge from any state, aborting any job, with no response issued for it.
REQ-021 SHALL drive div_reset=1 whenever reset is high, and div_run=0 during reset.
REQ-022 SHALL clear rsp_valid, rsp_div0, rsp_err, result, operand, timeout counter and ready-edge registers to 0 on reset.

Configuration
REQ-023 SHALL, with SIGNED_DIV_EN defined, honour req_signed=1: divide operand magnitudes, negate quotient when operand signs differ, give remainder the dividend's sign; divide-by-zero result unchanged.
REQ-024 SHALL, without SIGNED_DIV_EN, ignore req_signed and treat all operands as unsigned.

Structure
REQ-025 SHALL place the FSM state encoding and the divide-by-zero quotient constant in shared package div_pkg.
REQ-026 SHALL isolate the SIGNED_DIV_EN magnitude/sign-fix logic in sub-module div_sign_fix, instantiated only when the macro is defined.

Verification
REQ-027 SHALL cover: 100/7 unsigned -> quotient 14, remainder 2, div0=0, err=0; div_reset high exactly one cycle, then div_run until div_ready rises.
REQ-028 SHALL cover: 0x1234/0 -> rsp_valid one cycle after transfer, quotient 0xFFFFFFFF, remainder 0x1234, div0=1; div_run never asserted.
REQ-029 SHALL cover: with SIGNED_DIV_EN, -7/2 signed -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-030 SHALL cover: divider model holding div_ready low -> rsp_err=1, quotient 0, remainder 0 after TIMEOUT_CYCLES in RUN.
REQ-031 SHALL cover: rsp_ready held low 10 cycles -> rsp_valid and result stable, req_ready low throughout; back-to-back jobs complete in order.
REQ-032 SHALL cover: reset asserted mid-RUN -> IDLE next cycle, div_run=0, no rsp_valid; a following job completes correctly.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the divider job controller.
//   state_t        : controller FSM state encoding
//   DIV0_QUOT_BIT  : bit replicated across the quotient for a divide-by-zero result
package div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic DIV0_QUOT_BIT = 1'b1;

endpackage

// File: rtl/div_sign_fix.sv
// Signed-operand pre/post processing around an unsigned divider.
// Built only when SIGNED_DIV_EN is defined.
//   is_signed, dividend, divisor      : request operands (pre-processing side)
//   mag_dividend_c, mag_divisor_c     : operand magnitudes handed to the divider
//   neg_quot_c, neg_rem_c             : sign-fix flags to be latched with the job
//   neg_quot, neg_rem                 : latched sign-fix flags of the running job
//   raw_quotient, raw_remainder       : unsigned divider result
//   fix_quotient_c, fix_remainder_c   : sign-corrected result
module div_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             neg_quot,
    input  logic             neg_rem,
    input  logic [WIDTH-1:0] raw_quotient,
    input  logic [WIDTH-1:0] raw_remainder,
    output logic [WIDTH-1:0] mag_dividend_c,
    output logic [WIDTH-1:0] mag_divisor_c,
    output logic             neg_quot_c,
    output logic             neg_rem_c,
    output logic [WIDTH-1:0] fix_quotient_c,
    output logic [WIDTH-1:0] fix_remainder_c
);

    logic dvd_neg;
    logic dvs_neg;

    // Magnitudes in, sign fix-up out; the most negative value maps onto itself,
    // which is already its correct unsigned magnitude.
    always_comb begin
        dvd_neg         = is_signed & dividend[WIDTH-1];
        dvs_neg         = is_signed & divisor[WIDTH-1];
        mag_dividend_c  = dvd_neg ? (WIDTH'(0) - dividend) : dividend;
        mag_divisor_c   = dvs_neg ? (WIDTH'(0) - divisor) : divisor;
        neg_quot_c      = dvd_neg ^ dvs_neg;
        neg_rem_c       = dvd_neg;
        fix_quotient_c  = neg_quot ? (WIDTH'(0) - raw_quotient) : raw_quotient;
        fix_remainder_c = neg_rem ? (WIDTH'(0) - raw_remainder) : raw_remainder;
    end

endmodule

// File: rtl/div_job_ctrl.sv
// Job controller wrapping a multi-cycle CompDivider: accepts one request, clears
// and runs the divider, captures the result on a div_ready rising edge (or
// aborts on a watchdog timeout) and returns it on the response channel.
// Divide-by-zero bypasses the divider entirely.
// Optional: define SIGNED_DIV_EN to honour req_signed (two's-complement divide).
//   clk, reset                  : clock, synchronous active-high reset
//   req_*                       : job request channel (valid/ready)
//   rsp_*                       : result channel (valid/ready)
//   div_reset/run/dividend/divisor : drive to the divider
//   div_ready/quotient/remainder   : sampled from the divider
module div_job_ctrl
    import div_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    input  logic             req_signed,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_div0,
    output logic             rsp_err,
    output logic             div_reset,
    output logic             div_run,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_ready,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic             clr_q;
    logic             run_q;
    logic             rdy_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic             neg_quot_q;
    logic             neg_rem_q;

    logic [WIDTH-1:0] mag_dividend_c;
    logic [WIDTH-1:0] mag_divisor_c;
    logic             neg_quot_c;
    logic             neg_rem_c;
    logic [WIDTH-1:0] fix_quotient_c;
    logic [WIDTH-1:0] fix_remainder_c;

`ifdef SIGNED_DIV_EN
    div_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .is_signed       (req_signed),
        .dividend        (req_dividend),
        .divisor         (req_divisor),
        .neg_quot        (neg_quot_q),
        .neg_rem         (neg_rem_q),
        .raw_quotient    (div_quotient),
        .raw_remainder   (div_remainder),
        .mag_dividend_c  (mag_dividend_c),
        .mag_divisor_c   (mag_divisor_c),
        .neg_quot_c      (neg_quot_c),
        .neg_rem_c       (neg_rem_c),
        .fix_quotient_c  (fix_quotient_c),
        .fix_remainder_c (fix_remainder_c)
    );
`else
    logic unused_c;

    assign mag_dividend_c  = req_dividend;
    assign mag_divisor_c   = req_divisor;
    assign neg_quot_c      = 1'b0;
    assign neg_rem_c       = 1'b0;
    assign fix_quotient_c  = div_quotient;
    assign fix_remainder_c = div_remainder;
    assign unused_c        = ^{req_signed, neg_quot_q, neg_rem_q};
`endif

    // Reset must reach the divider in the same cycle, not one edge later.
    assign div_reset = reset | clr_q;
    assign div_run   = run_q & ~reset;

    // Controller FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_div0      <= 1'b0;
            rsp_err       <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            clr_q         <= 1'b0;
            run_q         <= 1'b0;
            rdy_q         <= 1'b0;
            tmo_cnt       <= '0;
            neg_quot_q    <= 1'b0;
            neg_rem_q     <= 1'b0;
        end else begin
            rdy_q <= div_ready;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready    <= 1'b0;
                        div_dividend <= mag_dividend_c;
                        div_divisor  <= mag_divisor_c;
                        neg_quot_q   <= neg_quot_c;
                        neg_rem_q    <= neg_rem_c;
                        tmo_cnt      <= '0;
                        if (req_divisor == '0) begin
                            state         <= ST_DONE;
                            rsp_valid     <= 1'b1;
                            rsp_quotient  <= {WIDTH{DIV0_QUOT_BIT}};
                            rsp_remainder <= req_dividend;
                            rsp_div0      <= 1'b1;
                            rsp_err       <= 1'b0;
                        end else begin
                            state <= ST_CLR;
                            clr_q <= 1'b1;
                            rdy_q <= 1'b0;
                        end
                    end
                end
                ST_CLR: begin
                    clr_q <= 1'b0;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    run_q <= 1'b1;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    // A ready edge wins over a watchdog expiry in the same cycle.
                    if (div_ready && !rdy_q) begin
                        run_q         <= 1'b0;
                        state         <= ST_DONE;
                        rsp_valid     <= 1'b1;
                        rsp_quotient  <= fix_quotient_c;
                        rsp_remainder <= fix_remainder_c;
                        rsp_div0      <= 1'b0;
                        rsp_err       <= 1'b0;
                    end else if (tmo_cnt == CNT_LAST) begin
                        run_q         <= 1'b0;
                        state         <= ST_DONE;
                        rsp_valid     <= 1'b1;
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_div0      <= 1'b0;
                        rsp_err       <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
